// File: rtl/program_loader.sv
// Boot-time loader: receives a big-endian (length, words, checksum) byte stream,
// writes each word to instruction memory and releases the core once the image verifies.
module program_loader #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_wen,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         WC_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [31:0]           DEPTH_W  = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LOAD, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [31:0]           csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        accept, last_byte;
    logic [31:0] assembled;

    assign in_ready   = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign accept     = in_valid && in_ready;
    assign last_byte  = accept && (byte_cnt_q == 2'd3);
    assign assembled  = {shift_q, in_data};

    assign imem_wen   = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = in_ready || imem_wen;
    assign done       = (state_q == S_DONE);
    assign cpu_run    = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        // Byte shifting is common to every field-collecting state.
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = assembled[23:0];
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    len_d      = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    addr_d     = '0;
                end
            end
            S_LEN: begin
                if (last_byte) begin
                    if (assembled == 32'd0 || assembled > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                        len_d   = assembled[CW-1:0];
                        addr_d  = '0;
                    end
                end
            end
            S_LOAD: begin
                if (last_byte) begin
                    state_d = S_WRITE;
                    wdata_d = assembled;
                    csum_d  = csum_q ^ assembled;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + WC_ONE;
                // Address stays on the last word so it never runs past len-1.
                if (word_cnt_d == len_q) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_LOAD;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            S_CSUM: begin
                if (last_byte) state_d = (assembled == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader; expected writes and final status come from
// a stream-parsing model of the image format.
module tb_program_loader;
    logic       clk = 1'b0, clr_n = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, imem_wen, cpu_run, busy, done, err;
    logic [7:0] imem_addr;
    logic [31:0] imem_wdata;

    int n_chk = 0, n_fail = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_d[$], got_d[$];
    logic [7:0]  exp_a[$], got_a[$];
    bit          exp_err;
    logic [31:0] exp_len;

    program_loader #(.DEPTH(256), .ADDR_WIDTH(8)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_wen(imem_wen), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every write; the port must not take a byte while writing.
    always @(negedge clk) begin
        if (imem_wen) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
            chk("in_ready_during_write", 32'(in_ready), 32'd0);
        end
    end

    function automatic logic [31:0] word_at(input int i);
        return {stim[i], stim[i+1], stim[i+2], stim[i+3]};
    endfunction

    // Reference: parse the image and derive writes and pass/fail.
    task automatic model();
        logic [31:0] x, w;
        exp_d.delete(); exp_a.delete();
        exp_err = 1'b1;
        exp_len = word_at(0);
        if (exp_len == 0 || exp_len > 256) return;
        x = 0;
        for (int i = 0; i < int'(exp_len); i++) begin
            w = word_at(4 + 4*i);
            exp_d.push_back(w);
            exp_a.push_back(8'(i));
            x ^= w;
        end
        exp_err = (word_at(4 + 4*int'(exp_len)) != x);
    endtask

    task automatic push32(input logic [31:0] w);
        stim.push_back(w[31:24]); stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);  stim.push_back(w[7:0]);
    endtask

    task automatic build(input logic [31:0] len_field, input int nw, input bit corrupt);
        logic [31:0] x, w;
        stim.delete();
        push32(len_field);
        x = 0;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            push32(w);
            x ^= w;
        end
        if (corrupt) x ^= (32'd1 << $urandom_range(0, 31));
        if (nw > 0) push32(x);
    endtask

    task automatic build_nominal(input logic [31:0] csum);
        stim.delete();
        push32(32'd2); push32(32'h20080005); push32(32'h01084020); push32(csum);
    endtask

    // Called at a negedge; returns at the negedge following the last accepted byte.
    task automatic drive(input bit gaps, input int nbytes);
        int idx = 0, stall = 0;
        bit acc;
        while (idx < nbytes) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = stim[idx];
            #1 acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                idx++;
                stall = 0;
            end else if (++stall > 100) begin
                chk("accept_timeout", 32'(idx), 32'(nbytes));
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_image(input string tag, input bit gaps);
        model();
        got_d.delete(); got_a.delete();
        pulse_start();
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_run_after_start"}, 32'(cpu_run), 32'd0);
        drive(gaps, stim.size());
        chk({tag, "_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(!exp_err));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_nwrites"}, 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk({tag, "_waddr"}, 32'(got_a[i]), 32'(exp_a[i]));
            chk({tag, "_wdata"}, got_d[i], exp_d[i]);
        end
        if (!exp_err) chk({tag, "_final_addr"}, 32'(imem_addr), exp_len - 1);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_hold_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_wen"}, 32'(imem_wen), 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 clr_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk); clr_n = 1'b1;
        @(negedge clk);

        build_nominal(32'h21004025); run_image("nominal", 1'b0);
        build(32'd0, 0, 1'b0);       run_image("len_zero", 1'b0);
        build(32'd257, 0, 1'b0);     run_image("len_257", 1'b0);
        build_nominal(32'h21004024); run_image("bad_csum", 1'b0);
        build_nominal(32'h21004025); run_image("gaps", 1'b1);

        // Reset in the middle of the second word's first bytes.
        build_nominal(32'h21004025);
        pulse_start();
        drive(1'b0, 6);
        #2 clr_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk); clr_n = 1'b1;
        @(negedge clk);
        run_image("after_reset", 1'b1);

        // Restart from DONE with a one-word zero image.
        stim.delete(); push32(32'd1); push32(32'd0); push32(32'd0);
        run_image("restart", 1'b0);

        build(32'd256, 256, 1'b0); run_image("len_max", 1'b1);

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: build(($urandom_range(0, 1) != 0) ? 32'd0 : 32'($urandom_range(257, 100000)), 0, 1'b0);
                1, 2: begin
                    int n = $urandom_range(1, 6);
                    build(32'(n), n, 1'b0);
                end
                default: begin
                    int n = $urandom_range(1, 6);
                    build(32'(n), n, 1'b1);
                end
            endcase
            run_image("random", $urandom_range(0, 1) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
